interface_controller_out: RTL and testbench
===========================================

// Module: interface_controller_out
// PURPOSE
//  Read-side decoder for the host command FIFO filled by the inbound interface controller.
//  Pops bytes and decodes the framed stream: command byte, then (send_data only) length byte, then payload.
//  Emits connect/disconnect pulses and a byte-serial message stream with start/end markers to the FIX engine.
// PARAMETERS
//  NUM_HOST     `HOST_ADDR_WIDTH  host address width in command byte; 1..5 (3+NUM_HOST<=8)
//  LEN_OVERHEAD 21                constant added to payload length in the length byte
// PORTS
//  clk                  in   1         single clock, rising edge
//  rst                  in   1         reset, asynchronous, active-low
//  empty_i              in   1         FIFO empty; show-ahead FIFO, data_i valid whenever !empty_i
//  data_i               in   8         FIFO head byte
//  readreq_o            out  1         pop FIFO head this cycle (combinational)
//  ready_i              in   1         downstream accepts message byte
//  connect_o            out  1         1-cycle pulse: connect command decoded
//  disconnect_o         out  1         1-cycle pulse: disconnect command decoded
//  host_addr_o          out  NUM_HOST  address of last decoded command; held until next command
//  msg_start_o          out  1         1-cycle pulse: send_data header done, msg_length_o valid
//  msg_length_o         out  8         payload length = length byte - LEN_OVERHEAD; held
//  message_o            out  8         payload byte
//  message_valid_o      out  1         message_o valid
//  msg_end_o            out  1         qualifies last payload byte (or with msg_start_o for length 0)
//  err_o                out  1         1-cycle pulse: bad opcode or length byte < LEN_OVERHEAD
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, all outputs 0 incl. host_addr_o/msg_length_o.
//  Command byte: [2:0]=opcode, [2+NUM_HOST:3]=host addr, upper bits ignored.
//   opcode 3'b000 connect, 3'b001 disconnect, 3'b010 send_data; others illegal.
//  readreq_o = !empty_i && (state!=DATA || ready_i || !message_valid_o); never pops when empty.
//  All decode outputs registered: 1-cycle latency from the popping cycle.
//  FSM:
//   IDLE: on pop, decode byte. connect/disconnect -> pulse + host_addr_o, stay IDLE.
//         send_data -> latch host_addr_o, go LEN. Illegal -> err_o, byte dropped, stay IDLE.
//   LEN:  on pop, L=data_i. L<LEN_OVERHEAD -> err_o, go IDLE (frame dropped).
//         L==LEN_OVERHEAD -> msg_start_o+msg_end_o same cycle, msg_length_o=0, go IDLE.
//         else msg_start_o, msg_length_o=L-LEN_OVERHEAD, counter=that value, go DATA.
//   DATA: output regs act as 1-deep skid: byte held while message_valid_o && !ready_i.
//         on pop: message_o=data_i, message_valid_o=1, counter--; counter hits 0 ->
//         msg_end_o=1 with that byte, go IDLE. message_valid_o drops after accept if no pop.
//  Empty mid-frame: stay in state, no outputs, counter held; resume on next byte (no timeout).
//  Back-to-back frames: a command byte may pop the cycle after the last payload byte is accepted.
//  Arithmetic: 8-bit unsigned; subtraction only after L>=LEN_OVERHEAD check; counter 8 bits, no wrap.
//  Pulses (connect/disconnect/start/err) are exactly one cycle; never two kinds in the same cycle,
//   except msg_start_o+msg_end_o for zero-length payload.
//  Reset mid-frame: immediate return to IDLE; remainder of the frame in the FIFO is then
//   decoded as commands (owner flushes the FIFO alongside).
// STRUCTURE
//  Shared package fix_if_pkg: opcode localparams (CONNECT/DISCONNECT/SEND_DATA), LEN_OVERHEAD,
//   decoder state enum {IDLE,LEN,DATA}; inbound controller to import the same opcodes.
//  No sub-module: FSM, counter and output skid register inline in one module.
// TESTING
//  FIFO 0x08 (NUM_HOST=1, addr1, connect) -> connect_o pulse 1 cycle later, host_addr_o=1.
//  FIFO 0x09 -> disconnect_o pulse, host_addr_o=1; no message outputs.
//  FIFO 0x0A,0x18,'A','B','C', ready_i=1 -> msg_start_o, msg_length_o=3; A,B,C on
//   consecutive cycles, msg_end_o with 'C'; state IDLE after.
//  As above, ready_i=0 for 4 cycles on 'B' -> 'B' held stable, readreq_o=0, no byte lost.
//  FIFO 0x07 then 0x0A,0x10 -> err_o on opcode, err_o on length 16; following 0x08 decodes.
//  Empty gap of 5 cycles between payload bytes, plus rst=0 mid-payload -> outputs 0 async, IDLE.

Source files
------------

// File: rtl/fix_if_pkg.sv
// Shared definitions for the host-command FIFO framing used by the inbound
// and outbound interface controllers: opcodes, length overhead and the
// outbound decoder state encoding.
package fix_if_pkg;

  // Default host address width carried in the command byte.
  localparam int HOST_ADDR_WIDTH = 1;

  // Command opcodes in bits [2:0] of the command byte.
  localparam logic [2:0] OP_CONNECT    = 3'b000;
  localparam logic [2:0] OP_DISCONNECT = 3'b001;
  localparam logic [2:0] OP_SEND_DATA  = 3'b010;

  // The length byte carries payload length plus this fixed overhead.
  localparam logic [7:0] LEN_OVERHEAD_DEF = 8'd21;

  // Outbound decoder states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } dec_state_e;

  // True for the three opcodes the decoder understands.
  function automatic logic is_legal_opcode(input logic [2:0] op);
    logic legal;
    case (op)
      OP_CONNECT, OP_DISCONNECT, OP_SEND_DATA: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/interface_controller_out.sv
// Read-side decoder for the host command FIFO. Pops the framed byte stream
// (command byte, length byte for send_data, then payload) and turns it into
// connect/disconnect pulses and a byte-serial message stream with start/end
// markers for the FIX engine. The message output registers double as a
// one-deep skid buffer so a held byte is never lost while ready_i is low.
module interface_controller_out
  import fix_if_pkg::*;
#(
  parameter int         NUM_HOST     = HOST_ADDR_WIDTH,
  parameter logic [7:0] LEN_OVERHEAD = LEN_OVERHEAD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                empty_i,
  input  logic [7:0]          data_i,
  output logic                readreq_o,
  input  logic                ready_i,
  output logic                connect_o,
  output logic                disconnect_o,
  output logic [NUM_HOST-1:0] host_addr_o,
  output logic                msg_start_o,
  output logic [7:0]          msg_length_o,
  output logic [7:0]          message_o,
  output logic                message_valid_o,
  output logic                msg_end_o,
  output logic                err_o
);

  dec_state_e state_r;
  logic [7:0] counter_r;

  logic [2:0]          opcode_s;
  logic [NUM_HOST-1:0] addr_s;
  logic [7:0]          payload_len_s;

  assign opcode_s      = data_i[2:0];
  assign addr_s        = data_i[2+NUM_HOST:3];
  // Only consumed once the length byte is known to be >= LEN_OVERHEAD.
  assign payload_len_s = data_i - LEN_OVERHEAD;

  // Pop whenever a byte is present, except in DATA while the skid register
  // still holds an unaccepted byte.
  always_comb begin
    readreq_o = 1'b0;
    if (empty_i) begin
      readreq_o = 1'b0;
    end else if (state_r != ST_DATA) begin
      readreq_o = 1'b1;
    end else begin
      readreq_o = ready_i || !message_valid_o;
    end
  end

  // Decoder FSM with counter and registered outputs, advanced on each pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      counter_r       <= 8'd0;
      connect_o       <= 1'b0;
      disconnect_o    <= 1'b0;
      host_addr_o     <= '0;
      msg_start_o     <= 1'b0;
      msg_length_o    <= 8'd0;
      message_o       <= 8'd0;
      message_valid_o <= 1'b0;
      msg_end_o       <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      connect_o    <= 1'b0;
      disconnect_o <= 1'b0;
      msg_start_o  <= 1'b0;
      err_o        <= 1'b0;

      // Skid register: release the byte once accepted; a zero-length end
      // marker (no byte attached) lasts a single cycle.
      if (message_valid_o && ready_i) begin
        message_valid_o <= 1'b0;
        msg_end_o       <= 1'b0;
      end else if (!message_valid_o) begin
        msg_end_o <= 1'b0;
      end else begin
        msg_end_o <= msg_end_o;
      end

      if (readreq_o) begin
        case (state_r)
          ST_IDLE: begin
            if (is_legal_opcode(opcode_s)) begin
              host_addr_o <= addr_s;
              case (opcode_s)
                OP_CONNECT:    connect_o    <= 1'b1;
                OP_DISCONNECT: disconnect_o <= 1'b1;
                OP_SEND_DATA:  state_r      <= ST_LEN;
                default:       state_r      <= ST_IDLE;
              endcase
            end else begin
              err_o   <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
          ST_LEN: begin
            if (data_i < LEN_OVERHEAD) begin
              err_o   <= 1'b1;
              state_r <= ST_IDLE;
            end else if (data_i == LEN_OVERHEAD) begin
              msg_start_o  <= 1'b1;
              msg_end_o    <= 1'b1;
              msg_length_o <= 8'd0;
              state_r      <= ST_IDLE;
            end else begin
              msg_start_o  <= 1'b1;
              msg_length_o <= payload_len_s;
              counter_r    <= payload_len_s;
              state_r      <= ST_DATA;
            end
          end
          ST_DATA: begin
            message_o       <= data_i;
            message_valid_o <= 1'b1;
            if (counter_r != 8'd0) begin
              counter_r <= counter_r - 8'd1;
            end else begin
              counter_r <= 8'd0;
            end
            if (counter_r <= 8'd1) begin
              msg_end_o <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              msg_end_o <= 1'b0;
              state_r   <= ST_DATA;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_interface_controller_out.sv
// Directed, table-driven bench for interface_controller_out (NUM_HOST=1).
// Each vector is one clock: inputs, expected readreq_o, and expected
// registered outputs after the following rising edge.
module tb_interface_controller_out;

  logic       clk;
  logic       rst;
  logic       empty_i;
  logic [7:0] data_i;
  logic       readreq_o;
  logic       ready_i;
  logic       connect_o;
  logic       disconnect_o;
  logic [0:0] host_addr_o;
  logic       msg_start_o;
  logic [7:0] msg_length_o;
  logic [7:0] message_o;
  logic       message_valid_o;
  logic       msg_end_o;
  logic       err_o;

  interface_controller_out #(.NUM_HOST(1), .LEN_OVERHEAD(8'd21)) dut (
    .clk(clk), .rst(rst), .empty_i(empty_i), .data_i(data_i),
    .readreq_o(readreq_o), .ready_i(ready_i), .connect_o(connect_o),
    .disconnect_o(disconnect_o), .host_addr_o(host_addr_o),
    .msg_start_o(msg_start_o), .msg_length_o(msg_length_o),
    .message_o(message_o), .message_valid_o(message_valid_o),
    .msg_end_o(msg_end_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output order: conn disc addr start len[8] msg[8] mv end err
  typedef struct {
    logic        empty;
    logic [7:0]  data;
    logic        ready;
    logic        exp_rd;
    logic [22:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [22:0] pk(input logic c, input logic d, input logic a,
                                     input logic s, input logic [7:0] l,
                                     input logic [7:0] m, input logic mv,
                                     input logic e, input logic er);
    return {c, d, a, s, l, m, mv, e, er};
  endfunction

  function automatic logic [22:0] actual_out();
    return {connect_o, disconnect_o, host_addr_o[0], msg_start_o, msg_length_o,
            message_o, message_valid_o, msg_end_o, err_o};
  endfunction

  task automatic add(input logic e, input logic [7:0] d, input logic r,
                     input logic rd, input logic [22:0] o);
    vec_t v;
    v.empty = e; v.data = d; v.ready = r; v.exp_rd = rd; v.exp_out = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on falling edge, check readreq_o combinationally, check regs after rise.
  task automatic step(input logic e, input logic [7:0] d, input logic r,
                      input logic rd, input logic [22:0] o, input string tag);
    @(negedge clk);
    empty_i = e; data_i = d; ready_i = r;
    #1;
    check({tag, "_rd"}, {22'd0, readreq_o}, {22'd0, rd});
    @(posedge clk);
    #1;
    check({tag, "_out"}, actual_out(), o);
  endtask

  initial begin
    rst = 1'b0; empty_i = 1'b1; data_i = 8'd0; ready_i = 1'b1;
    #12;
    check("reset_out", actual_out(), 23'd0);
    @(negedge clk);
    rst = 1'b1;

    // connect / disconnect, host address 1
    add(0, 8'h08, 1, 1, pk(1,0,1,0,8'd0,8'h00,0,0,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd0,8'h00,0,0,0));
    add(0, 8'h09, 1, 1, pk(0,1,1,0,8'd0,8'h00,0,0,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd0,8'h00,0,0,0));
    // send_data "ABC", ready high
    add(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd0,8'h00,0,0,0));
    add(0, 8'h18, 1, 1, pk(0,0,1,1,8'd3,8'h00,0,0,0));
    add(0, 8'h41, 1, 1, pk(0,0,1,0,8'd3,8'h41,1,0,0));
    add(0, 8'h42, 1, 1, pk(0,0,1,0,8'd3,8'h42,1,0,0));
    add(0, 8'h43, 1, 1, pk(0,0,1,0,8'd3,8'h43,1,1,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd3,8'h43,0,0,0));
    // same frame with 4-cycle stall on 'B'
    add(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd3,8'h43,0,0,0));
    add(0, 8'h18, 1, 1, pk(0,0,1,1,8'd3,8'h43,0,0,0));
    add(0, 8'h41, 1, 1, pk(0,0,1,0,8'd3,8'h41,1,0,0));
    add(0, 8'h42, 1, 1, pk(0,0,1,0,8'd3,8'h42,1,0,0));
    for (int i = 0; i < 4; i++)
      add(0, 8'h43, 0, 0, pk(0,0,1,0,8'd3,8'h42,1,0,0));
    add(0, 8'h43, 1, 1, pk(0,0,1,0,8'd3,8'h43,1,1,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd3,8'h43,0,0,0));
    // illegal opcode, then short length, then a good connect
    add(0, 8'h07, 1, 1, pk(0,0,1,0,8'd3,8'h43,0,0,1));
    add(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd3,8'h43,0,0,0));
    add(0, 8'h10, 1, 1, pk(0,0,1,0,8'd3,8'h43,0,0,1));
    add(0, 8'h08, 1, 1, pk(1,0,1,0,8'd3,8'h43,0,0,0));
    // zero-length payload: start and end together
    add(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd3,8'h43,0,0,0));
    add(0, 8'h15, 1, 1, pk(0,0,1,1,8'd0,8'h43,0,1,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd0,8'h43,0,0,0));
    // length 2 with a 5-cycle empty gap between payload bytes
    add(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd0,8'h43,0,0,0));
    add(0, 8'h17, 1, 1, pk(0,0,1,1,8'd2,8'h43,0,0,0));
    add(0, 8'h58, 1, 1, pk(0,0,1,0,8'd2,8'h58,1,0,0));
    for (int i = 0; i < 5; i++)
      add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd2,8'h58,0,0,0));
    add(0, 8'h59, 1, 1, pk(0,0,1,0,8'd2,8'h59,1,1,0));
    add(1, 8'h00, 1, 0, pk(0,0,1,0,8'd2,8'h59,0,0,0));
    // disconnect on host 0
    add(0, 8'h01, 1, 1, pk(0,1,0,0,8'd2,8'h59,0,0,0));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].empty, vecs[i].data, vecs[i].ready, vecs[i].exp_rd,
           vecs[i].exp_out, $sformatf("vec%0d", i));

    // Reset mid-payload: outputs clear asynchronously, leftover bytes decode as commands.
    step(0, 8'h0A, 1, 1, pk(0,0,1,0,8'd2,8'h59,0,0,0), "rs_cmd");
    step(0, 8'h18, 1, 1, pk(0,0,1,1,8'd3,8'h59,0,0,0), "rs_len");
    step(0, 8'h41, 1, 1, pk(0,0,1,0,8'd3,8'h41,1,0,0), "rs_a");
    @(negedge clk);
    empty_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_reset", actual_out(), 23'd0);
    @(negedge clk);
    rst = 1'b1;
    // 0x42 is now a send_data command for host 0; 0x16 gives length 1.
    step(0, 8'h42, 1, 1, pk(0,0,0,0,8'd0,8'h00,0,0,0), "rs_b_cmd");
    step(0, 8'h16, 1, 1, pk(0,0,0,1,8'd1,8'h00,0,0,0), "rs_b_len");
    step(0, 8'h5A, 1, 1, pk(0,0,0,0,8'd1,8'h5A,1,1,0), "rs_b_data");
    step(1, 8'h00, 1, 0, pk(0,0,0,0,8'd1,8'h5A,0,0,0), "rs_b_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
